// File: rtl/bus_rx_endpoint_pkg.sv
// bus_rx_endpoint_pkg: shared constants, types and helpers for the bus receive endpoint
// Contents: ID field width, broadcast ID, drop counter type, destination extraction.
package bus_rx_endpoint_pkg;
    localparam int    ID_BITS      = 8;
    localparam logic [ID_BITS-1:0] BROADCAST_ID = 8'hFF;
    typedef logic [7:0] drop_t;
    localparam drop_t DROP_MAX     = 8'hFF;
    // Destination ID sits in the top ID_BITS of a w-bit word, passed zero-extended.
    function automatic logic [ID_BITS-1:0] get_dest(input logic [63:0] word, input int w);
        return word[w-1 -: ID_BITS];
    endfunction
endpackage

// File: rtl/bus_fifo.sv
// bus_fifo: first-word-fall-through FIFO that accepts a push while full if a pop happens in the same cycle
// Ports: clk, reset_n (async active-low); push/d_push write side; pop/d_pop read side
//        (d_pop zero when empty); count occupancy; full, empty flags.
module bus_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       d_push,
    input  logic                   pop,
    output logic [WIDTH-1:0]       d_pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_rd;
    assign empty = r_cnt == '0;
    assign full  = r_cnt == (AW+1)'(DEPTH);
    assign w_rd  = pop && !empty;
    // When full, the slot being read this cycle is the one being written.
    assign w_wr  = push && (!full || pop);
    assign count = r_cnt;
    assign d_pop = empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= w_wr ? r_wr + 1'b1 : r_wr;
            r_rd  <= w_rd ? r_rd + 1'b1 : r_rd;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr] <= d_push;
endmodule

// File: rtl/bus_rx_endpoint.sv
// bus_rx_endpoint: device-side bus receiver with destination-ID filter, FWFT buffer and overflow drop counter
// Ports: clk, reset_n (async active-low); push/d_push from bus; pop/d_pop/pndng to device;
//        full, count occupancy; drop_cnt saturating count of matching words lost to overflow.
module bus_rx_endpoint
    import bus_rx_endpoint_pkg::*;
#(
    parameter int          width   = 16,
    parameter int          devices = 4,
    parameter logic [7:0]  id      = 8'd0,
    parameter int          depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [width-1:0]       d_push,
    input  logic                   pop,
    output logic [width-1:0]       d_pop,
    output logic                   pndng,
    output logic                   full,
    output logic [$clog2(depth):0] count,
    output drop_t                  drop_cnt
);
    logic [ID_BITS-1:0] w_dest;
    logic               w_match;
    logic               w_empty;
    drop_t              r_drop;
    assign w_dest  = get_dest(64'(d_push), width);
    // An out-of-range own ID can only ever receive broadcasts.
    assign w_match = push && ((int'(id) < devices && w_dest == id) || w_dest == BROADCAST_ID);
    assign pndng   = !w_empty;
    assign drop_cnt = r_drop;
    bus_fifo #(.WIDTH(width), .DEPTH(depth)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (w_match),
        .d_push (d_push),
        .pop    (pop),
        .d_pop  (d_pop),
        .count  (count),
        .full   (full),
        .empty  (w_empty)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_drop <= '0;
        else if (w_match && full && !pop && r_drop != DROP_MAX) r_drop <= r_drop + 1'b1;
endmodule

// File: tb/tb_bus_rx_endpoint.sv
module tb_bus_rx_endpoint;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        push;
    logic [15:0] d_push;
    logic        pop;
    logic [15:0] d_pop;
    logic        pndng;
    logic        full;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] q[$];
    int          m_drop;

    always #5 clk = ~clk;

    bus_rx_endpoint #(.width(16), .devices(4), .id(8'd0), .depth(8)) dut (
        .clk(clk), .reset_n(reset_n), .push(push), .d_push(d_push), .pop(pop),
        .d_pop(d_pop), .pndng(pndng), .full(full), .count(count), .drop_cnt(drop_cnt)
    );

    function automatic logic [31:0] exp_status();
        logic [15:0] h;
        h = (q.size() > 0) ? q[0] : 16'h0;
        return {q.size() > 0, q.size() == 8, 4'(q.size()), 8'(m_drop), h};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; push = 1'b0; pop = 1'b0; d_push = '0;
        q.delete(); m_drop = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic cyc(input logic p, input logic [15:0] d, input logic po);
        logic [7:0] dest;
        bit f, m;
        push = p; d_push = d; pop = po;
        @(posedge clk);
        dest = d[15:8];
        m = p && (dest == 8'h00 || dest == 8'hFF);
        f = q.size() == 8;
        if (po && q.size() > 0) void'(q.pop_front());
        if (m && (!f || po)) q.push_back(d);
        if (m && f && !po && m_drop < 255) m_drop++;
        #1 push = 1'b0; pop = 1'b0; d_push = 'x;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({pndng, full, count, drop_cnt, d_pop} !== 32'h0) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", {pndng, full, count, drop_cnt, d_pop}, 32'h0);
        end
    endtask

    task automatic test_basic();
        cyc(1, 16'h0012, 0);
        n_chk++;
        if ({pndng, count, d_pop} !== {1'b1, 4'd1, 16'h0012}) begin
            n_fail++; $display("FAIL basic_push: got %b/%0d/%h want 1/1/0012", pndng, count, d_pop);
        end
        cyc(0, 16'h0, 1);
        n_chk++;
        if ({pndng, d_pop} !== {1'b0, 16'h0}) begin
            n_fail++; $display("FAIL basic_pop: got %b/%h want 0/0000", pndng, d_pop);
        end
    endtask

    task automatic test_filter();
        do_reset();
        cyc(1, 16'h0155, 0);
        n_chk++;
        if ({pndng, count, drop_cnt} !== 13'h0) begin
            n_fail++; $display("FAIL filter_reject: got %b/%0d/%0d want 0/0/0", pndng, count, drop_cnt);
        end
        cyc(1, 16'hFF34, 0);
        n_chk++;
        if ({pndng, d_pop} !== {1'b1, 16'hFF34}) begin
            n_fail++; $display("FAIL filter_bcast: got %b/%h want 1/ff34", pndng, d_pop);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 0);
        n_chk++;
        if ({full, count} !== {1'b1, 4'd8}) begin
            n_fail++; $display("FAIL fill_full: got %b/%0d want 1/8", full, count);
        end
        cyc(1, 16'h0009, 0);
        n_chk++;
        if ({drop_cnt, count} !== {8'd1, 4'd8}) begin
            n_fail++; $display("FAIL overflow_drop: got %0d/%0d want 1/8", drop_cnt, count);
        end
        for (int i = 1; i <= 8; i++) begin
            n_chk++;
            if (d_pop !== 16'(i)) begin
                n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", i, d_pop, 16'(i));
            end
            cyc(0, 16'h0, 1);
        end
        n_chk++;
        if (pndng !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got %b want 0", pndng);
        end
    endtask

    task automatic test_full_pushpop();
        logic [15:0] exp [8];
        exp = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h000A};
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 0);
        cyc(1, 16'h000A, 1);
        n_chk++;
        if ({full, count, drop_cnt} !== {1'b1, 4'd8, 8'd0}) begin
            n_fail++; $display("FAIL full_pushpop: got %b/%0d/%0d want 1/8/0", full, count, drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (d_pop !== exp[i]) begin
                n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", i, d_pop, exp[i]);
            end
            cyc(0, 16'h0, 1);
        end
        n_chk++;
        if ({pndng, count} !== 5'h0) begin
            n_fail++; $display("FAIL wrap_empty: got %b/%0d want 0/0", pndng, count);
        end
    endtask

    task automatic test_empty_pushpop();
        do_reset();
        cyc(1, 16'h00AA, 1);
        n_chk++;
        if ({count, d_pop} !== {4'd1, 16'h00AA}) begin
            n_fail++; $display("FAIL empty_pushpop: got %0d/%h want 1/00aa", count, d_pop);
        end
    endtask

    task automatic test_saturation();
        while (q.size() < 8) cyc(1, 16'h00B0, 0);
        for (int i = 0; i < 300; i++) cyc(1, {8'hFF, 8'($urandom)}, 0);
        n_chk++;
        if (drop_cnt !== 8'd255 || m_drop != 255) begin
            n_fail++; $display("FAIL drop_saturate: got %0d want 255 (model %0d)", drop_cnt, m_drop);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 16'h0020 + 16'(i), 0);
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({pndng, count, drop_cnt, d_pop} !== 29'h0) begin
            n_fail++; $display("FAIL async_reset: got %b/%0d/%0d/%h want 0/0/0/0000", pndng, count, drop_cnt, d_pop);
        end
        q.delete(); m_drop = 0;
        @(negedge clk) reset_n = 1'b1;
        cyc(1, 16'h00C3, 0);
        n_chk++;
        if ({count, d_pop} !== {4'd1, 16'h00C3}) begin
            n_fail++; $display("FAIL post_reset_push: got %0d/%h want 1/00c3", count, d_pop);
        end
        cyc(0, 16'h0, 1);
        n_chk++;
        if (pndng !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_stale: got %b want 0", pndng);
        end
    endtask

    task automatic test_random();
        logic [7:0] ids [4];
        logic [7:0] dest;
        int pop_pct;
        ids = '{8'h00, 8'h01, 8'hFF, 8'h00};
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            pop_pct = ((i / 200) % 2 == 0) ? 25 : 75;
            dest = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ids[$urandom_range(0, 3)];
            cyc($urandom_range(0, 99) < 70, {dest, 8'($urandom)}, $urandom_range(0, 99) < pop_pct);
            n_chk++;
            if ({pndng, full, count, drop_cnt, d_pop} !== exp_status()) begin
                n_fail++; $display("FAIL random[%0d]: got %h want %h", i, {pndng, full, count, drop_cnt, d_pop}, exp_status());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_fill_overflow();
        test_full_pushpop();
        test_empty_pushpop();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_rx_endpoint.md
Name: bus_rx_endpoint

Overview:
- Device-side receive endpoint of the shared broadcast bus; the bus deposits words here, the device drains them.
- Filters each incoming word by its destination-ID field.
- Buffers accepted words in a first-word-fall-through FIFO and exposes them through the pending/pop handshake.
- Counts words dropped on overflow; one instance per device, `devices` instances in the full DUT.

Parameters:
- width, 16, bus word width in bits; destination ID occupies bits [width-1:width-8].
- devices, 4, number of devices on the bus; legal own-ID range is 0..devices-1.
- id, 0, this endpoint's own device ID (8-bit value).
- depth, 8, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  bus clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- push  input  1  bus presents a valid word this cycle.
- d_push  input  width  word from bus, sampled when push=1.
- pop  input  1  device consumes the head word this cycle.
- d_pop  output  width  head word, valid whenever pndng=1; all-zero when empty.
- pndng  output  1  FIFO non-empty.
- full  output  1  FIFO holds depth words.
- count  output  $clog2(depth)+1  current occupancy.
- drop_cnt  output  8  saturating count of accepted-address words lost to overflow.

Behaviour:
- Reset (async assert, sync release): rd/wr pointers=0, count=0, pndng=0, full=0, d_pop=0, drop_cnt=0. Reset mid-operation discards all buffered words immediately.
- Address match: dest=d_push[width-1:width-8]. Match when dest==id or dest==8'hFF (broadcast). Non-matching words are ignored silently and are not counted.
- Write: push=1, match=1, and (not full, or pop=1 this cycle) -> store at wr_ptr; wr_ptr+1 modulo depth.
- Pop: pop=1 and pndng=1 -> rd_ptr+1 modulo depth. pop when empty is ignored, with no underflow and no pointer change.
- Simultaneous push+pop:
  - empty: push stored, pop ignored; count becomes 1.
  - full: both occur; count stays depth; drop_cnt unchanged.
  - otherwise: count unchanged.
- Overflow: push=1, match=1, full=1, pop=0 -> word discarded, drop_cnt+1. drop_cnt saturates at 255.
- Latency: a word written at edge N appears on d_pop with pndng=1 after edge N (one-cycle push-to-visible). d_pop is combinational from the head entry (FWFT); popping at edge N exposes the next word after edge N.
- Flags: pndng=(count!=0); full=(count==depth). Both are registered-consistent with count and have no combinational path from push/pop.
- Pointers are $clog2(depth) bits and wrap naturally; count disambiguates full from empty.
- Data is stored unmodified, ID field included.
- X on d_push while push=0 has no effect.

Decomposition:
- Shared package (paquetes): ID_MSB offset constant (8-bit ID field), BROADCAST_ID=8'hFF, function get_dest(word) returning the top 8 bits, and typedef for drop counter width.
- Sub-module bus_fifo: generic FWFT FIFO (width, depth; push/pop/data/count/full/empty) with the full-with-pop acceptance rule.
- bus_rx_endpoint wraps bus_fifo and owns the address filter and the drop counter.

Test Plan:
- Reset, then push d_push=16'h0012 with id=0 -> after 1 edge pndng=1, d_pop=16'h0012, count=1; pop -> pndng=0, d_pop=0.
- Push 16'h0155 with id=0 -> ignored: pndng=0, count=0, drop_cnt=0. Push broadcast 16'hFF34 -> accepted, d_pop=16'hFF34.
- Push 8 matching words 16'h0001..16'h0008 (depth=8) -> full=1, count=8. 9th push 16'h0009 -> dropped, drop_cnt=1. Pop all 8 -> order 0001..0008, then pndng=0.
- When full, push 16'h000A with pop in the same cycle -> count stays 8, drop_cnt unchanged. Draining yields 0002..0008 then 000A, exercising pointer wrap.
- Push+pop in the same cycle while empty with 16'h00AA -> count=1, d_pop=16'h00AA. 300 overflow pushes while full -> drop_cnt=255 (saturated).
- With 3 words buffered, assert reset_n=0 mid-cycle -> outputs clear immediately (pndng=0, count=0, drop_cnt=0). After release, the first push is at slot 0 and no stale data appears.
